// File: rtl/dmem_mmio.sv
// Data RAM plus memory-mapped TX byte FIFO, status, free-running cycle counter and halt latch.
// Loads are combinational; stores, FIFO traffic and halt state update on the rising clock edge.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_RUN  | normal operation, cycle counter running, stores accepted
// ST_HALT | ecall seen; counter frozen, stores dropped, FIFO still drains
module dmem_mmio #(
   parameter int DEPTH_WORDS = 256,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] maddr,
   input  logic [31:0] wdata,
   input  logic        mwe,
   output logic [31:0] md,
   input  logic        ecall_in,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        halted
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [29:0] TXDATA_W = 30'h3FFF_C000;
   localparam logic [29:0] STATUS_W = 30'h3FFF_C001;
   localparam logic [29:0] CYCLE_W  = 30'h3FFF_C002;

   typedef enum logic {ST_RUN, ST_HALT} state_t;

   state_t      state;
   logic [31:0] ram [DEPTH_WORDS];
   logic [7:0]  fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic        overflow;
   logic [31:0] cycle_cnt;

   logic [29:0] waddr;
   logic        ram_sel, txd_sel, status_sel, cycle_sel;
   logic        store_en, push, pop, push_ok, drop, ovf_clr;
   logic        full, empty;
   logic [3:0]  cnt4;
   logic        unused_bits;

   assign waddr      = maddr[31:2];
   assign ram_sel    = (waddr < 30'(DEPTH_WORDS));
   assign txd_sel    = (waddr == TXDATA_W);
   assign status_sel = (waddr == STATUS_W);
   assign cycle_sel  = (waddr == CYCLE_W);
   assign unused_bits = ^{maddr[1:0], wdata[31:9]};

   assign halted   = (state == ST_HALT);
   assign store_en = mwe && !halted;
   assign full     = (count == CW'(FIFO_DEPTH));
   assign empty    = (count == '0);
   assign tx_valid = !empty;
   // Empty forces zero so tx_data is clean during and right after reset.
   assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

   assign push    = store_en && txd_sel;
   assign pop     = tx_valid && tx_ready;
   assign push_ok = push && (!full || pop);
   assign drop    = push && full && !pop;
   assign ovf_clr = store_en && status_sel && wdata[8];
   assign cnt4    = 4'(count);

   // overflow sits at bit 8 so the same bit position clears it on write.
   always_comb begin
      md = 32'h0;
      if (ram_sel)
         md = ram[waddr[AW-1:0]];
      else if (status_sel)
         md = {23'b0, overflow, cnt4, 2'b00, full, empty};
      else if (cycle_sel)
         md = cycle_cnt;
   end

   always_ff @(posedge clk) begin
      if (store_en && ram_sel)
         ram[waddr[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         fifo_mem[wr_ptr] <= wdata[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_RUN;
         cycle_cnt <= 32'h0;
      end else begin
         case (state)
            ST_RUN: begin
               cycle_cnt <= cycle_cnt + 32'h1;
               if (ecall_in)
                  state <= ST_HALT;
            end
            default: state <= ST_HALT;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: stimulus queues expected load data and TX bytes,
// a negedge monitor pops and compares whenever a load is issued or a byte is accepted.
module tb_dmem_mmio;

   localparam logic [31:0] A_TX  = 32'hFFFF_0000;
   localparam logic [31:0] A_ST  = 32'hFFFF_0004;
   localparam logic [31:0] A_CYC = 32'hFFFF_0008;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] maddr, wdata, md;
   logic        mwe, ecall_in, tx_valid, tx_ready, halted;
   logic [7:0]  tx_data;

   dmem_mmio #(.DEPTH_WORDS(256), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .maddr(maddr), .wdata(wdata), .mwe(mwe), .md(md),
      .ecall_in(ecall_in), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {string name; logic [31:0] exp;} rd_exp_t;
   rd_exp_t     rd_q[$];
   logic [7:0]  tx_q[$];
   logic        rd_req;
   rd_exp_t     mon_e;
   int          total = 0;
   int          bad = 0;

   // Reference cycle counter: runs from reset release until the edge after ecall.
   logic [31:0] tb_cyc;
   logic        tb_halt;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         tb_cyc  <= 32'h0;
         tb_halt <= 1'b0;
      end else begin
         if (!tb_halt) tb_cyc <= tb_cyc + 32'h1;
         if (ecall_in) tb_halt <= 1'b1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rd_req) begin
         if (rd_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_unexpected: got %h want none", md);
         end else begin
            mon_e = rd_q.pop_front();
            chk(mon_e.name, md, mon_e.exp);
         end
      end
      if (!rst && tx_valid && tx_ready) begin
         if (tx_q.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_extra: got %h want none", tx_data);
         end else begin
            chk("tx_byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         step();
         mwe = 1'b0; rd_req = 1'b0; ecall_in = 1'b0;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      step();
      maddr = a; wdata = d; mwe = 1'b1; rd_req = 1'b0;
   endtask

   task automatic rd(input string name, input logic [31:0] a, input logic [31:0] e);
      step();
      maddr = a; mwe = 1'b0; rd_req = 1'b1;
      rd_q.push_back('{name, e});
   endtask

   task automatic rd_cyc(input string name);
      step();
      maddr = A_CYC; mwe = 1'b0; rd_req = 1'b1;
      rd_q.push_back('{name, tb_cyc});
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (tx_valid && n < 40) begin
         idle(1);
         n++;
      end
      chk(name, {31'h0, tx_valid}, 32'h0);
      chk({name, "_left"}, 32'(tx_q.size()), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      mwe = 1'b0; maddr = A_ST; wdata = 32'h0; ecall_in = 1'b0;
      tx_ready = 1'b0; rd_req = 1'b0;
      #12;
      chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      chk("rst_halted",   {31'h0, halted},   32'h0);
      chk("rst_tx_data",  {24'h0, tx_data},  32'h0);
      chk("rst_status",   md,                32'h0000_0001);
      #4 rst = 1'b0;

      // RAM, aliasing of byte offsets, decode boundaries
      wr(32'h10, 32'hDEAD_BEEF);
      rd("ram_rd_10", 32'h10, 32'hDEAD_BEEF);
      rd("ram_rd_13", 32'h13, 32'hDEAD_BEEF);
      wr(32'h0, 32'h1111_1111);
      wr(32'h400, 32'h2222_2222);
      wr(32'h3FC, 32'hA5A5_A5A5);
      wr(A_CYC, 32'h0);
      rd("ram_no_alias", 32'h0, 32'h1111_1111);
      rd("ram_last", 32'h3FC, 32'hA5A5_A5A5);
      rd("txdata_rd", A_TX, 32'h0);
      rd("unmapped_rd", 32'h400, 32'h0);
      rd_cyc("cycle_rd");

      // two bytes held under back-pressure, then delivered in order
      wr(A_TX, 32'h0000_0141); tx_q.push_back(8'h41);
      wr(A_TX, 32'h0000_0042); tx_q.push_back(8'h42);
      idle(3);
      chk("hold_valid", {31'h0, tx_valid}, 32'h1);
      chk("hold_data",  {24'h0, tx_data},  32'h41);
      rd("status_two", A_ST, 32'h0000_0020);
      idle(1);
      tx_ready = 1'b1;
      drain("drain_two");
      tx_ready = 1'b0;
      rd("status_empty", A_ST, 32'h0000_0001);

      // overflow: 9 pushes into 8 entries, 9th byte dropped
      for (int i = 0; i < 9; i++) begin
         wr(A_TX, 32'h50 + 32'(i));
         if (i < 8) tx_q.push_back(8'(8'h50 + i));
      end
      idle(1);
      rd("status_ovf", A_ST, 32'h0000_0182);

      // push and pop together while full
      step();
      maddr = A_TX; wdata = 32'h59; mwe = 1'b1; tx_ready = 1'b1; rd_req = 1'b0;
      tx_q.push_back(8'h59);
      idle(1);
      tx_ready = 1'b0;
      rd("status_pushpop", A_ST, 32'h0000_0182);
      wr(A_ST, 32'h0000_00FF);
      rd("status_noclr", A_ST, 32'h0000_0182);
      wr(A_ST, 32'h0000_0100);
      rd("status_clr", A_ST, 32'h0000_0082);
      idle(1);
      tx_ready = 1'b1;
      drain("drain_full");
      tx_ready = 1'b0;
      rd("status_after", A_ST, 32'h0000_0001);

      // asynchronous reset with bytes queued
      wr(A_TX, 32'h61);
      wr(A_TX, 32'h62);
      wr(A_TX, 32'h63);
      idle(1);
      chk("pre_rst_valid", {31'h0, tx_valid}, 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", {31'h0, tx_valid}, 32'h0);
      chk("async_rst_data",  {24'h0, tx_data},  32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      rd("status_post_rst", A_ST, 32'h0000_0001);
      rd("ram_kept", 32'h10, 32'hDEAD_BEEF);
      idle(1);

      // halt around cycle 100
      begin
         int n = 0;
         while (tb_cyc < 32'd100 && n < 300) begin
            idle(1);
            n++;
         end
         chk("reach_cycle_100", {31'h0, tb_cyc >= 32'd100}, 32'h1);
      end
      step();
      ecall_in = 1'b1;
      idle(1);
      chk("halted_set", {31'h0, halted}, 32'h1);
      rd_cyc("cycle_frozen_a");
      idle(5);
      rd_cyc("cycle_frozen_b");
      wr(32'h10, 32'h1234_5678);
      rd("ram_halt_wr", 32'h10, 32'hDEAD_BEEF);
      wr(A_TX, 32'h77);
      idle(1);
      chk("halt_no_push", {31'h0, tx_valid}, 32'h0);
      rd("status_halt", A_ST, 32'h0000_0001);
      idle(2);
      chk("halted_sticky", {31'h0, halted}, 32'h1);
      chk("reads_consumed", 32'(rd_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
